// File: rtl/ultra_small_core_pkg.sv
// Shared definitions for the bit-serial RV32I subset core.
// Covers instruction field encodings, FSM states, ALU control and an address helper.
package ultra_small_core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM1 = 3'd3,
    ST_MEM2 = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_CMP = 3'd5
  } alu_e;

  // Clears the byte offset so PC and data addresses stay word-aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ultra_small_core_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 reads as zero and is never written.
module ultra_small_core_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] mem [0:31];

  // Write port; contents deliberately not reset so they survive a core reset.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports with x0 hardwired to zero.
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem[raddr1];
    rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem[raddr2];
  end

endmodule

// File: rtl/ultra_small_core.sv
// Bit-serial RV32I subset core: one operand bit per cycle through a 1-bit ALU.
// IF -> ID -> EX(32) -> [MEM(2)] -> WB; unsupported instructions park the core in HALT.
module ultra_small_core
  import ultra_small_core_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] ROUT,
  output logic        HALT,
  output logic [31:0] I_ADDR,
  input  logic [31:0] I_DATA,
  output logic [31:0] D_ADDR,
  input  logic [31:0] D_DATA,
  output logic [31:0] D_WDATA,
  output logic [3:0]  D_WE
);

  state_e      state_r, state_n_s;
  alu_e        alu_r, dec_alu_s;
  logic [31:0] pc_r, ir_r, a_r, b_r, res_r, load_r;
  logic [31:0] rout_r, d_addr_r, d_wdata_r;
  logic [3:0]  d_we_r;
  logic [4:0]  cnt_r;
  logic        carry_r, mism_r, halt_r;

  logic [6:0]  opcode_s, f7_s;
  logic [2:0]  f3_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, dec_imm_s;
  logic        dec_ok_s, use_imm_s;
  logic        is_load_s, is_store_s, is_branch_s, writes_s, taken_s, we_s;
  logic [31:0] rdata1_s, rdata2_s, wb_data_s, res_n_s, pc_next_s;
  logic        b_bit_s, sum_s, carry_n_s, res_bit_s;

  assign opcode_s = ir_r[6:0];
  assign rd_s     = ir_r[11:7];
  assign f3_s     = ir_r[14:12];
  assign rs1_s    = ir_r[19:15];
  assign rs2_s    = ir_r[24:20];
  assign f7_s     = ir_r[31:25];
  assign imm_i_s  = {{20{ir_r[31]}}, ir_r[31:20]};
  assign imm_s_s  = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
  assign imm_b_s  = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};

  assign is_load_s   = (opcode_s == OP_LOAD);
  assign is_store_s  = (opcode_s == OP_STORE);
  assign is_branch_s = (opcode_s == OP_BRANCH);
  assign writes_s    = (opcode_s == OP_R) || (opcode_s == OP_I) || is_load_s;

  ultra_small_core_regfile regfile0 (
    .clk    (CLK),
    .raddr1 (rs1_s),
    .raddr2 (rs2_s),
    .we     (we_s),
    .waddr  (rd_s),
    .wdata  (wb_data_s),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s)
  );

  // Instruction decode: legality, ALU operation and B-operand source.
  always_comb begin
    dec_ok_s  = 1'b0;
    dec_alu_s = ALU_ADD;
    use_imm_s = 1'b0;
    dec_imm_s = imm_i_s;
    case (opcode_s)
      OP_R: begin
        if (f7_s == F7_BASE) begin
          case (f3_s)
            F3_ADD:  begin dec_ok_s = 1'b1; dec_alu_s = ALU_ADD; end
            F3_XOR:  begin dec_ok_s = 1'b1; dec_alu_s = ALU_XOR; end
            F3_OR:   begin dec_ok_s = 1'b1; dec_alu_s = ALU_OR;  end
            F3_AND:  begin dec_ok_s = 1'b1; dec_alu_s = ALU_AND; end
            default: dec_ok_s = 1'b0;
          endcase
        end else if ((f7_s == F7_SUB) && (f3_s == F3_ADD)) begin
          dec_ok_s  = 1'b1;
          dec_alu_s = ALU_SUB;
        end else begin
          dec_ok_s = 1'b0;
        end
      end
      OP_I: begin
        use_imm_s = 1'b1;
        case (f3_s)
          F3_ADD:  begin dec_ok_s = 1'b1; dec_alu_s = ALU_ADD; end
          F3_XOR:  begin dec_ok_s = 1'b1; dec_alu_s = ALU_XOR; end
          F3_OR:   begin dec_ok_s = 1'b1; dec_alu_s = ALU_OR;  end
          F3_AND:  begin dec_ok_s = 1'b1; dec_alu_s = ALU_AND; end
          default: dec_ok_s = 1'b0;
        endcase
      end
      OP_LOAD: begin
        use_imm_s = 1'b1;
        dec_ok_s  = (f3_s == F3_W);
      end
      OP_STORE: begin
        use_imm_s = 1'b1;
        dec_imm_s = imm_s_s;
        dec_ok_s  = (f3_s == F3_W);
      end
      OP_BRANCH: begin
        dec_alu_s = ALU_CMP;
        dec_ok_s  = (f3_s == F3_BEQ) || (f3_s == F3_BNE);
      end
      default: dec_ok_s = 1'b0;
    endcase
  end

  // One-bit ALU slice; SUB inverts B and relies on the carry preset to 1.
  always_comb begin
    b_bit_s   = b_r[0] ^ (alu_r == ALU_SUB);
    sum_s     = a_r[0] ^ b_bit_s ^ carry_r;
    carry_n_s = (a_r[0] & b_bit_s) | (carry_r & (a_r[0] ^ b_bit_s));
    case (alu_r)
      ALU_XOR: res_bit_s = a_r[0] ^ b_r[0];
      ALU_OR:  res_bit_s = a_r[0] | b_r[0];
      ALU_AND: res_bit_s = a_r[0] & b_r[0];
      default: res_bit_s = sum_s;
    endcase
    res_n_s = {res_bit_s, res_r[31:1]};
  end

  // Writeback selection and next PC.
  always_comb begin
    wb_data_s = is_load_s ? load_r : res_r;
    if (f3_s == F3_BNE) begin
      taken_s = mism_r;
    end else begin
      taken_s = ~mism_r;
    end
    if (is_branch_s && taken_s) begin
      pc_next_s = word_align(pc_r + imm_b_s);
    end else begin
      pc_next_s = word_align(pc_r + PC_STEP);
    end
    we_s = (state_r == ST_WB) && writes_s && !RST;
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IF:   state_n_s = ST_ID;
      ST_ID:   state_n_s = dec_ok_s ? ST_EX : ST_HALT;
      ST_EX: begin
        if (cnt_r == 5'd31) begin
          state_n_s = (is_load_s || is_store_s) ? ST_MEM1 : ST_WB;
        end else begin
          state_n_s = ST_EX;
        end
      end
      ST_MEM1: state_n_s = ST_MEM2;
      ST_MEM2: state_n_s = ST_WB;
      ST_WB:   state_n_s = ST_IF;
      ST_HALT: state_n_s = ST_HALT;
      default: state_n_s = ST_IF;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IF;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Datapath registers; the store strobe defaults low so it lasts one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r      <= 32'd0;
      ir_r      <= 32'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      res_r     <= 32'd0;
      load_r    <= 32'd0;
      carry_r   <= 1'b0;
      mism_r    <= 1'b0;
      cnt_r     <= 5'd0;
      alu_r     <= ALU_ADD;
      halt_r    <= 1'b0;
      rout_r    <= 32'd0;
      d_we_r    <= 4'b0000;
      d_addr_r  <= 32'd0;
      d_wdata_r <= 32'd0;
    end else begin
      d_we_r <= 4'b0000;
      case (state_r)
        ST_IF: ir_r <= I_DATA;
        ST_ID: begin
          if (dec_ok_s) begin
            a_r     <= rdata1_s;
            b_r     <= use_imm_s ? dec_imm_s : rdata2_s;
            res_r   <= 32'd0;
            cnt_r   <= 5'd0;
            mism_r  <= 1'b0;
            alu_r   <= dec_alu_s;
            carry_r <= (dec_alu_s == ALU_SUB);
          end else begin
            halt_r <= 1'b1;
          end
        end
        ST_EX: begin
          a_r     <= {1'b0, a_r[31:1]};
          b_r     <= {1'b0, b_r[31:1]};
          res_r   <= res_n_s;
          carry_r <= carry_n_s;
          mism_r  <= mism_r | (a_r[0] ^ b_r[0]);
          cnt_r   <= cnt_r + 5'd1;
          if ((cnt_r == 5'd31) && (is_load_s || is_store_s)) begin
            d_addr_r <= word_align(res_n_s);
            if (is_store_s) begin
              d_we_r    <= 4'b1111;
              d_wdata_r <= rdata2_s;
            end
          end
        end
        ST_MEM2: load_r <= D_DATA;
        ST_WB: begin
          if (writes_s && (rd_s != 5'd0)) begin
            rout_r <= wb_data_s;
          end
          pc_r <= pc_next_s;
        end
        default: ;
      endcase
    end
  end

  assign ROUT    = rout_r;
  assign HALT    = halt_r;
  assign I_ADDR  = pc_r;
  assign D_ADDR  = d_addr_r;
  assign D_WDATA = d_wdata_r;
  assign D_WE    = d_we_r;

endmodule

// File: tb/tb_ultra_small_core.sv
// Self-checking bench for ultra_small_core: directed programs plus a random program,
// each instruction checked against an instruction-level reference model.
module tb_ultra_small_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ROUT, I_ADDR, I_DATA, D_ADDR, D_DATA, D_WDATA;
  logic        HALT;
  logic [3:0]  D_WE;

  logic [31:0] imem   [0:63];
  logic [31:0] dmem   [0:63];
  logic [31:0] m_dmem [0:63];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc, m_rout;

  int          checks = 0;
  int          errors = 0;
  int          we_pulses = 0;
  logic [31:0] we_addr, we_data;
  logic [3:0]  we_val;

  ultra_small_core dut (
    .CLK(CLK), .RST(RST), .ROUT(ROUT), .HALT(HALT), .I_ADDR(I_ADDR), .I_DATA(I_DATA),
    .D_ADDR(D_ADDR), .D_DATA(D_DATA), .D_WDATA(D_WDATA), .D_WE(D_WE)
  );

  always #5 CLK = ~CLK;

  assign I_DATA = imem[I_ADDR[7:2]];

  always @(posedge CLK) begin
    D_DATA <= dmem[D_ADDR[7:2]];
    if (D_WE == 4'b1111) dmem[D_ADDR[7:2]] = D_WDATA;
  end

  always @(negedge CLK) begin
    if (D_WE != 4'b0000) begin
      we_pulses = we_pulses + 1;
      we_addr   = D_ADDR;
      we_data   = D_WDATA;
      we_val    = D_WE;
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3,
      input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Architectural model: executes one instruction, returns its cycle cost (0 = illegal).
  function automatic int model_exec(input logic [31:0] ins);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, ii, is, ib, r, ea;
    bit          ok, taken;
    opc = ins[6:0];   rd  = ins[11:7];  f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a  = (rs1 == 5'd0) ? 32'd0 : m_regs[rs1];
    b  = (rs2 == 5'd0) ? 32'd0 : m_regs[rs2];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ok = 1'b1; r = 32'd0;
    case (opc)
      7'h33: begin
        if (f7 == 7'h00 && f3 == 3'd0) r = a + b;
        else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
        else if (f7 == 7'h00 && f3 == 3'd4) r = a ^ b;
        else if (f7 == 7'h00 && f3 == 3'd6) r = a | b;
        else if (f7 == 7'h00 && f3 == 3'd7) r = a & b;
        else ok = 1'b0;
      end
      7'h13: begin
        case (f3)
          3'd0: r = a + ii;
          3'd4: r = a ^ ii;
          3'd6: r = a | ii;
          3'd7: r = a & ii;
          default: ok = 1'b0;
        endcase
      end
      7'h03: begin
        ea = a + ii;
        if (f3 == 3'd2) r = m_dmem[ea[7:2]]; else ok = 1'b0;
      end
      7'h23: begin
        ea = a + is;
        if (f3 == 3'd2) begin
          m_dmem[ea[7:2]] = b;
          m_pc = m_pc + 32'd4;
          return 37;
        end
        ok = 1'b0;
      end
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1) begin
          taken = (f3 == 3'd0) ? (a == b) : (a != b);
          m_pc = taken ? (m_pc + ib) : (m_pc + 32'd4);
          return 35;
        end
        ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return 0;
    if (rd != 5'd0) begin
      m_regs[rd] = r;
      m_rout     = r;
    end
    m_pc = m_pc + 32'd4;
    return (opc == 7'h03) ? 37 : 35;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    m_pc   = 32'd0;
    m_rout = 32'd0;
  endtask

  // Run one instruction for exactly its modelled duration, then compare state.
  task automatic step_instr(input string tag);
    logic [31:0] ins;
    logic [4:0]  rd;
    int          n;
    ins = imem[m_pc[7:2]];
    rd  = ins[11:7];
    n   = model_exec(ins);
    if (n == 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $error("FAIL %s observed=illegal expected=legal instruction", tag);
      n = 35;
    end
    repeat (n) @(posedge CLK);
    #1;
    check({tag, "_pc"}, I_ADDR, m_pc);
    check({tag, "_rout"}, ROUT, m_rout);
    check({tag, "_halt"}, {31'd0, HALT}, 32'd0);
    if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13 || ins[6:0] == 7'h03) && rd != 5'd0)
      check({tag, "_rd"}, dut.regfile0.mem[rd], m_regs[rd]);
  endtask

  initial begin
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    int          kind;
    for (int i = 0; i < 64; i++) begin
      imem[i] = enc_i(12'd1, 5'd9, 3'd0, 5'd9, 7'h13);
      dmem[i] = 32'd0;
      m_dmem[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

    // Register preload and the ADDI corner cases.
    imem[0] = enc_i(12'd13, 5'd0, 3'd0, 5'd1, 7'h13);
    imem[1] = enc_i(12'd15, 5'd0, 3'd0, 5'd2, 7'h13);
    imem[2] = enc_i(12'd0, 5'd0, 3'd0, 5'd4, 7'h13);
    imem[3] = enc_i(12'd0, 5'd0, 3'd0, 5'd5, 7'h13);
    imem[4] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd7, 7'h13);
    imem[5] = enc_i(12'd5, 5'd1, 3'd0, 5'd0, 7'h13);
    imem[6] = enc_r(7'h00, 5'd1, 5'd0, 3'd0, 5'd8);
    do_reset();
    check("reset_pc", I_ADDR, 32'd0);
    check("reset_rout", ROUT, 32'd0);
    check("reset_halt", {31'd0, HALT}, 32'd0);
    check("reset_dwe", {28'd0, D_WE}, 32'd0);
    for (int i = 0; i < 7; i++) step_instr($sformatf("pre%0d", i));
    check("addi_neg1_x7", dut.regfile0.mem[7], 32'hFFFF_FFFF);
    check("x0_stays_zero", dut.regfile0.mem[8], 32'd13);

    // Five-op loop closed by BEQ x4,x5,-20 at PC 20.
    imem[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    imem[1] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3);
    imem[3] = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3);
    imem[4] = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3);
    imem[5] = enc_b(13'h1FEC, 3'd0, 5'd4, 5'd5);
    do_reset();
    step_instr("add");
    check("add_rout28", ROUT, 32'd28);
    check("add_x3", dut.regfile0.mem[3], 32'd28);
    step_instr("sub");
    check("sub_rout", ROUT, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) step_instr($sformatf("loop_a%0d", i));
    check("beq_back_to_0", I_ADDR, 32'd0);
    for (int i = 0; i < 6; i++) step_instr($sformatf("loop_b%0d", i));

    // Store then load through the synchronous data memory.
    imem[0] = enc_s(12'd8, 5'd2, 5'd0);
    imem[1] = enc_i(12'd8, 5'd0, 3'd2, 5'd6, 7'h03);
    do_reset();
    we_pulses = 0;
    step_instr("sw");
    check("sw_we_pulses", we_pulses, 32'd1);
    check("sw_we_val", {28'd0, we_val}, 32'h0000_000F);
    check("sw_addr", we_addr, 32'd8);
    check("sw_wdata", we_data, 32'd15);
    step_instr("lw");
    check("lw_x6", dut.regfile0.mem[6], 32'd15);
    check("lw_rout", ROUT, 32'd15);

    // Random program: ADDI preloads followed by mixed ALU, memory and branch ops.
    for (int i = 0; i < 8; i++)
      imem[i] = enc_i(12'($urandom), 5'd0, 3'd0, 5'(i + 1), 7'h13);
    for (int i = 8; i < 40; i++) begin
      rd   = 5'($urandom_range(1, 8));
      rs1  = 5'($urandom_range(0, 8));
      rs2  = 5'($urandom_range(0, 8));
      imm  = 12'($urandom);
      kind = $urandom_range(0, 10);
      case (kind)
        0: imem[i] = enc_r(7'h00, rs2, rs1, 3'd0, rd);
        1: imem[i] = enc_r(7'h20, rs2, rs1, 3'd0, rd);
        2: imem[i] = enc_r(7'h00, rs2, rs1, 3'd4, rd);
        3: imem[i] = enc_r(7'h00, rs2, rs1, 3'd6, rd);
        4: imem[i] = enc_r(7'h00, rs2, rs1, 3'd7, rd);
        5: imem[i] = enc_i(imm, rs1, 3'd0, rd, 7'h13);
        6: imem[i] = enc_i(imm, rs1, 3'd4, rd, 7'h13);
        7: imem[i] = enc_i(imm, rs1, 3'd6, rd, 7'h13);
        8: imem[i] = enc_i(imm, rs1, 3'd7, rd, 7'h13);
        9: begin
          if ($urandom_range(0, 1) == 1)
            imem[i] = enc_s(12'(4 * $urandom_range(0, 15)), rs2, 5'd0);
          else
            imem[i] = enc_i(12'(4 * $urandom_range(0, 15)), 5'd0, 3'd2, rd, 7'h03);
        end
        default: imem[i] = enc_b(13'd8, 3'($urandom_range(0, 1)), rs1, rs2);
      endcase
    end
    do_reset();
    for (int i = 0; i < 32; i++) step_instr($sformatf("rnd%0d", i));

    // Unsupported opcode: HALT right after ID, then frozen until reset.
    imem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13);
    imem[1] = 32'h0000_007F;
    do_reset();
    step_instr("pre_halt");
    @(posedge CLK); #1;
    check("halt_low_after_if", {31'd0, HALT}, 32'd0);
    @(posedge CLK); #1;
    check("halt_high_after_id", {31'd0, HALT}, 32'd1);
    we_pulses = 0;
    repeat (20) @(posedge CLK);
    #1;
    check("halt_sticky", {31'd0, HALT}, 32'd1);
    check("halt_pc_frozen", I_ADDR, 32'd4);
    check("halt_no_store", we_pulses, 32'd0);
    check("halt_rout_kept", ROUT, 32'd1);
    check("halt_x9_kept", dut.regfile0.mem[9], 32'd1);
    do_reset();
    check("halt_cleared", {31'd0, HALT}, 32'd0);
    check("halt_reset_pc", I_ADDR, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
